i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
Shares one byte-level i2c_master engine between NREQ independent requesters (sensor poller, config loader, debug port, ...). It runs a round-robin grant, latches the winner's address, direction and data, and issues a single start pulse to the master. It then waits for completion and returns read data and status to the winner. It sits between the requester logic and i2c_master on the clk_50 domain.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 1023, clk_50 cycles allowed in WAIT before forced abort (only with I2C_ARB_TIMEOUT_EN)

Ports:
clk_50  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester transaction request, level
req_rw  in  NREQ  per-requester direction, 1=read 0=write
req_addr  in  7*NREQ  per-requester 7-bit slave address, requester i at [7i+6:7i]
req_wdata  in  8*NREQ  per-requester write byte, requester i at [8i+7:8i]
gnt  out  NREQ  one-hot grant, held IDLE-exit through RESP
done  out  NREQ  one-cycle completion pulse to the winner
rdata  out  8  read byte, valid in the done cycle, held until next done
err  out  1  NACK/timeout flag, valid in the done cycle
m_start  out  1  one-cycle start pulse to i2c_master
m_rw  out  1  latched direction
m_addr  out  7  latched address
m_wdata  out  8  latched write byte
m_busy  in  1  master engine busy
m_done  in  1  master completion pulse
m_ack_err  in  1  master NACK flag, qualified by m_done
m_rdata  in  8  master read byte, qualified by m_done

Behaviour:
- Clock and reset: one clock, clk_50. reset is synchronous and active-high. All state is updated on the rising edge of clk_50.
- Reset values: gnt=0, done=0, rdata=0, err=0, m_start=0, m_rw=0, m_addr=0, m_wdata=0. FSM goes to IDLE, rr_ptr=0, timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req!=0 and m_busy=0: select the first set req bit searching from rr_ptr upward, wrapping NREQ-1 -> 0.
  - Register the one-hot gnt, latch m_rw/m_addr/m_wdata from that requester's slice, go to ISSUE.
  - If m_busy=1, no grant is issued.
- ISSUE: m_start=1 for exactly one cycle, then go to WAIT. Clear the timeout counter.
- WAIT:
  - On m_done: rdata<=m_rdata if m_rw=1, otherwise rdata is unchanged. err<=m_ack_err. Go to RESP.
  - The counter increments every WAIT cycle.
- RESP:
  - done[winner]=1 and err valid for one cycle. gnt<=0.
  - rr_ptr<=(winner+1) mod NREQ. Go to IDLE.
  - err returns to 0 in the following cycle.
- Latency: req sampled in IDLE at edge N -> gnt at N+1, m_start high during cycle N+1. m_done seen at edge M -> done high during cycle M+1. With idle master, minimum req-to-done is 3 cycles plus master time.
- Requesters must hold their slices stable only until the grant cycle; fields are latched then.
- Dropping req after grant does not cancel the transaction; done still pulses.
- A requester that keeps req high after done is eligible again, but is lowest priority because of the rotated pointer.
- m_done arriving in IDLE or ISSUE is ignored.
- Simultaneous requests: only the pointer-order winner is granted. Others wait without loss.
- Reset mid-transaction: returns to the reset values above immediately; no done is issued. The master is reset separately via its own state_reset.
- At most one gnt bit and one done bit are ever high.

Optional Feature:
I2C_ARB_TIMEOUT_EN
- Defined: in WAIT, when the counter reaches TIMEOUT with no m_done, force err=1, leave rdata unchanged, go to RESP.
  - m_done in the same cycle as the limit takes precedence, giving a normal completion.
  - The counter is 10 bits wide, sized to cover TIMEOUT.
- Undefined: no counter is built. WAIT exits only on m_done; err reflects only m_ack_err.

Test Plan:
- Single write: req=0001, addr0=0x50, rw=0, wdata=0xA5 -> gnt=0001 next cycle; one m_start with m_addr=0x50, m_wdata=0xA5; bench m_done with ack_err=0 -> done=0001 for 1 cycle, err=0.
- Read: req=0100, addr2=0x68, rw=1; bench returns m_rdata=0x3C -> done=0100, rdata=0x3C held afterwards.
- Round robin: req=1111 held, master responds in 5 cycles -> grant order 0,1,2,3,0; no requester starved; gnt always one-hot.
- NACK plus busy gating: m_busy=1 while req=0010 -> no gnt. Release m_busy -> grant. Bench sets m_ack_err=1 -> done=0010 with err=1.
- Timeout (macro on, TIMEOUT=20): no m_done -> done pulses 21 cycles after m_start with err=1. m_done on the limit cycle -> err=m_ack_err.
- Reset mid-WAIT: assert reset for 1 cycle -> all outputs 0 next edge, no done; the next req is granted starting from requester 0.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter
// Shares one byte-level i2c_master engine between NREQ requesters.
// A round-robin pick in IDLE latches the winner's address, direction and
// write byte. The arbiter then pulses m_start once, waits for m_done, and
// returns rdata/err together with a one-cycle done pulse to the winner.
//
// Ports:
//   clk_50, reset        rising-edge clock, synchronous active-high reset
//   req/req_rw           per-requester request level and direction (1=read)
//   req_addr/req_wdata   per-requester 7-bit address / 8-bit write byte slices
//   gnt, done            one-hot grant (held until RESP ends), one-hot done pulse
//   rdata, err           read byte (held) and NACK/timeout flag (done cycle only)
//   m_start/m_rw/m_addr/m_wdata   request to the master engine
//   m_busy/m_done/m_ack_err/m_rdata  status from the master engine
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT
// cycles without m_done (err=1, rdata unchanged).
module i2c_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              m_start,
  output logic              m_rw,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_wdata,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_ack_err,
  input  logic [7:0]        m_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Reject configurations the 3-bit pointer / 10-bit counter cannot cover.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_cfg
    $error("i2c_txn_arbiter: NREQ must be 2..8 and TIMEOUT 1..1023");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            m_start_q, m_start_d;
  logic            m_rw_q, m_rw_d;
  logic [6:0]      m_addr_q, m_addr_d;
  logic [7:0]      m_wdata_q, m_wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [9:0]      cnt_q, cnt_d;
`endif

  // (base + k) mod NREQ for k < NREQ, without a divider.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin pick: first set req bit at or above rr_ptr, wrapping.
  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && req[wrap_add(rr_ptr_q, k)]) begin
        pick_idx = wrap_add(rr_ptr_q, k);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    m_start_d = 1'b0;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld && !m_busy) begin
          win_d     = pick_idx;
          gnt_d     = NREQ'(1) << pick_idx;
          m_rw_d    = req_rw[pick_idx];
          m_addr_d  = req_addr[7*pick_idx +: 7];
          m_wdata_d = req_wdata[8*pick_idx +: 8];
          m_start_d = 1'b1;   // high during the ISSUE cycle only
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 10'd1;
`endif
        if (m_done) begin
          // m_done wins over a coincident timeout.
          if (m_rw_q) rdata_d = m_rdata;
          err_d   = m_ack_err;
          done_d  = gnt_q;
          state_d = ST_RESP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_d == 10'(TIMEOUT)) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        gnt_d    = '0;
        err_d    = 1'b0;
        rr_ptr_d = wrap_add(win_q, 1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      m_start_q <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      m_start_q <= m_start_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign m_start = m_start_q;
  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Testbench for i2c_txn_arbiter: directed transactions, a transaction-phase
// reference model compared every cycle, and literal expectations per test.
module tb_i2c_txn_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 20;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk_50 = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, req_rw, gnt, done;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [7:0]        rdata, m_wdata, m_rdata;
  logic              err, m_start, m_rw, m_busy, m_done, m_ack_err;
  logic [6:0]        m_addr;

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk_50(clk_50), .reset(reset), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .m_start(m_start), .m_rw(m_rw),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_ack_err(m_ack_err), .m_rdata(m_rdata)
  );

  always #5 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model (transaction phases) ----------------
  // phase 0: no transaction, 1: start cycle, 2: master running, 3: done cycle
  int              md_phase = 0, md_owner = 0, md_ptr = 0, md_wait = 0;
  logic [NREQ-1:0] e_gnt = '0, e_done = '0;
  logic [7:0]      e_rdata = '0, e_wdata = '0;
  logic            e_err = 1'b0, e_start = 1'b0, e_rw = 1'b0;
  logic [6:0]      e_addr = '0;

  function automatic int first_from(input int p, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  always @(posedge clk_50) begin
    if (reset) begin
      md_phase <= 0; md_ptr <= 0; md_owner <= 0; md_wait <= 0;
      e_gnt <= '0; e_done <= '0; e_rdata <= '0; e_err <= 1'b0;
      e_start <= 1'b0; e_rw <= 1'b0; e_addr <= '0; e_wdata <= '0;
    end else begin
      case (md_phase)
        0: if (req != 0 && !m_busy) begin
          md_owner <= first_from(md_ptr, req);
          e_gnt    <= NREQ'(1) << first_from(md_ptr, req);
          e_rw     <= req_rw[first_from(md_ptr, req)];
          e_addr   <= req_addr[7*first_from(md_ptr, req) +: 7];
          e_wdata  <= req_wdata[8*first_from(md_ptr, req) +: 8];
          e_start  <= 1'b1;
          md_phase <= 1;
        end
        1: begin e_start <= 1'b0; md_wait <= 0; md_phase <= 2; end
        2: if (m_done) begin
          if (e_rw) e_rdata <= m_rdata;
          e_err <= m_ack_err; e_done <= e_gnt; md_phase <= 3;
        end else if (TO_EN && md_wait + 1 == TO) begin
          e_err <= 1'b1; e_done <= e_gnt; md_phase <= 3;
        end else md_wait <= md_wait + 1;
        default: begin
          e_done <= '0; e_err <= 1'b0; e_gnt <= '0;
          md_ptr <= (md_owner + 1) % NREQ; md_phase <= 0;
        end
      endcase
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk_50) begin
    if (cmp_en) begin
      chk("cyc_gnt", gnt, e_gnt);
      chk("cyc_done", done, e_done);
      chk("cyc_rdata", rdata, e_rdata);
      chk("cyc_err", err, e_err);
      chk("cyc_m_start", m_start, e_start);
      chk("cyc_m_rw", m_rw, e_rw);
      chk("cyc_m_addr", m_addr, e_addr);
      chk("cyc_m_wdata", m_wdata, e_wdata);
      chk("cyc_onehot", ($countones(gnt) <= 1 && $countones(done) <= 1), 1);
    end
  end

  // ---------------- master responder ----------------
  logic [NREQ-1:0] s_gnt, s_done;
  logic [7:0]      s_rdata, s_mwdata;
  logic [6:0]      s_maddr;
  logic            s_err, s_mrw;
  int              s_dly;

  // Wait for m_start, then pulse m_done lat cycles later (lat<0: never).
  task automatic serve(input int lat, input logic [7:0] rd, input logic ack, input logic drop);
    int k = 0;
    while (m_start !== 1'b1 && k < 100) begin @(negedge clk_50); k++; end
    chk("start_seen", (k < 100), 1);
    s_gnt = gnt; s_maddr = m_addr; s_mwdata = m_wdata; s_mrw = m_rw;
    if (drop) req = '0;
    s_dly = 0; s_done = '0; s_rdata = '0; s_err = 1'b0;
    while (s_dly < 400) begin
      @(negedge clk_50); s_dly++;
      m_done = (s_dly == lat); m_rdata = rd; m_ack_err = ack;
      if (done != 0) begin s_done = done; s_rdata = rdata; s_err = err; break; end
    end
    m_done = 1'b0; m_ack_err = 1'b0;
    $display("txn: gnt=%b done=%b addr=%h wdata=%h rw=%b rdata=%h err=%b dly=%0d",
             s_gnt, s_done, s_maddr, s_mwdata, s_mrw, s_rdata, s_err, s_dly);
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req = '0; req_rw = '0; m_busy = 1'b0; m_done = 1'b0;
    m_ack_err = 1'b0; m_rdata = 8'hEE;
    req_addr  = {7'h77, 7'h68, 7'h21, 7'h50};
    req_wdata = {8'h33, 8'h22, 8'h11, 8'hA5};
    repeat (3) @(negedge clk_50);
    cmp_en = 1'b1;
    chk("rst_gnt", gnt, 0); chk("rst_done", done, 0); chk("rst_m_start", m_start, 0);
    chk("rst_m_addr", m_addr, 0); chk("rst_rdata", rdata, 0);
    reset = 1'b0;

    // Round robin with all requests held, master answering in 5 cycles.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(5, 8'hEE, 1'b0, (i == 4));
      chk("rr_gnt", s_gnt, 32'(1) << rr_exp[i]);
      chk("rr_done", s_done, 32'(1) << rr_exp[i]);
      chk("rr_latency", s_dly, 6);
    end
    repeat (3) @(negedge clk_50);

    // Single write from requester 0.
    req = 4'b0001;
    serve(3, 8'hEE, 1'b0, 1'b1);
    chk("wr_gnt", s_gnt, 4'b0001); chk("wr_done", s_done, 4'b0001);
    chk("wr_addr", s_maddr, 7'h50); chk("wr_wdata", s_mwdata, 8'hA5);
    chk("wr_err", s_err, 0); chk("wr_rdata_unchanged", s_rdata, 8'h00);
    repeat (2) @(negedge clk_50);

    // Read from requester 2.
    req_rw = 4'b0100; req = 4'b0100;
    serve(4, 8'h3C, 1'b0, 1'b1);
    chk("rd_gnt", s_gnt, 4'b0100); chk("rd_done", s_done, 4'b0100);
    chk("rd_addr", s_maddr, 7'h68); chk("rd_rw", s_mrw, 1); chk("rd_rdata", s_rdata, 8'h3C);
    repeat (3) @(negedge clk_50);
    chk("rd_rdata_held", rdata, 8'h3C);

    // Busy gating then NACK from requester 1.
    req_rw = 4'b0000; m_busy = 1'b1; req = 4'b0010;
    repeat (4) @(negedge clk_50);
    chk("busy_no_gnt", gnt, 0);
    m_busy = 1'b0;
    serve(2, 8'h55, 1'b1, 1'b1);
    chk("nack_gnt", s_gnt, 4'b0010); chk("nack_done", s_done, 4'b0010);
    chk("nack_err", s_err, 1); chk("nack_rdata_kept", s_rdata, 8'h3C);
    @(negedge clk_50);
    chk("err_cleared", err, 0); chk("done_one_cycle", done, 0);

`ifdef I2C_ARB_TIMEOUT_EN
    // Timeout with no m_done, then m_done exactly on the limit cycle.
    req = 4'b0010;
    serve(-1, 8'h00, 1'b0, 1'b1);
    chk("to_done", s_done, 4'b0010); chk("to_err", s_err, 1); chk("to_latency", s_dly, 21);
    repeat (2) @(negedge clk_50);
    req = 4'b0010;
    serve(20, 8'h00, 1'b0, 1'b1);
    chk("to_edge_done", s_done, 4'b0010); chk("to_edge_err", s_err, 0);
    chk("to_edge_latency", s_dly, 21);
    repeat (2) @(negedge clk_50);
`endif

    // Reset during WAIT of requester 3; pointer must restart at 0.
    req = 4'b1000;
    begin
      int k = 0;
      while (m_start !== 1'b1 && k < 100) begin @(negedge clk_50); k++; end
      chk("rst_txn_start", (k < 100), 1);
    end
    chk("rst_txn_gnt", gnt, 4'b1000);
    req = '0;
    repeat (2) @(negedge clk_50);
    reset = 1'b1;
    @(negedge clk_50);
    reset = 1'b0;
    chk("midrst_gnt", gnt, 0); chk("midrst_done", done, 0); chk("midrst_err", err, 0);
    chk("midrst_m_addr", m_addr, 0); chk("midrst_m_wdata", m_wdata, 0);
    chk("midrst_rdata", rdata, 0);
    repeat (3) @(negedge clk_50);
    chk("midrst_no_done", done, 0);
    req = 4'b1111;
    serve(2, 8'h00, 1'b0, 1'b1);
    chk("post_rst_gnt", s_gnt, 4'b0001); chk("post_rst_done", s_done, 4'b0001);
    repeat (3) @(negedge clk_50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
